data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder for the 16-bit accumulator CPU: services the controller's rd_mem (LDR)
//  and wr_mem (STR) strobes with a fixed, configurable wait-state latency.
//  Returns read data and a one-cycle ack. Drives busy so the datapath can gate enPC until ack.
//  Sits between controller/datapath and on-chip data RAM.
// PARAMETERS
//  DATA_W       16   data word width
//  ADDR_W       8    address width
//  DEPTH        200  implemented words (<= 2**ADDR_W)
//  WAIT_STATES  2    extra cycles between request sample and ack (0..15)
// PORTS
//  clk      in   1        single clock, rising edge
//  rst_n    in   1        asynchronous, active-low reset
//  rd_mem   in   1        read request (level, held until ack)
//  wr_mem   in   1        write request (level, held until ack)
//  addr     in   ADDR_W   word address, sampled with request
//  wdata    in   DATA_W   write data (R0), sampled with request
//  rdata    out  DATA_W   read data, valid in ack cycle, held until next read ack
//  ack      out  1        one-cycle completion pulse
//  busy     out  1        stall: request outstanding and not yet acked
//  err      out  1        one-cycle pulse: protocol/range error, coincident with ack
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, rdata=0, ack=0, err=0, wait counter=0.
//    RAM contents are not reset. Reset mid-access aborts it; an uncommitted write is never committed.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    With WAIT_STATES=0: IDLE -> RESP directly.
//  - IDLE: on a clk edge with rd_mem^wr_mem=1, latch addr, wdata, and op. Load counter=WAIT_STATES.
//  - WAIT: decrement counter each cycle; go to RESP on the edge where counter reaches 0.
//  - RESP: ack=1 for exactly one cycle.
//    Write: RAM[addr] commits on the edge entering RESP.
//    Read: rdata=RAM[addr] registered on the edge entering RESP.
//    Always returns to IDLE.
//  - Latency: request seen at edge N -> ack high in cycle N+WAIT_STATES+1.
//    Minimum request-to-request spacing: WAIT_STATES+2 cycles.
//  - busy = (IDLE & (rd_mem|wr_mem)) | WAIT. Combinational; 0 in RESP, so enPC fires with ack.
//  - Request still high in the cycle after RESP is treated as a new request (the CPU has advanced).
//  - rd_mem & wr_mem both high in IDLE: no access. Go directly to RESP with ack=1, err=1.
//    rdata is unchanged.
//  - Request inputs changing during WAIT/RESP are ignored (latched values are used).
//  - Back-to-back STR then LDR to the same addr returns the new data.
// CONFIGURATION
//  BOUNDS_CHECK_EN defined:
//    An access with addr >= DEPTH completes with normal latency, ack=1, err=1.
//    A write is dropped; a read returns rdata=0.
//  BOUNDS_CHECK_EN undefined:
//    Out-of-range writes are silently dropped; reads return 0; err is never set by range.
//    Dual-strobe err still applies.
// TESTING
//  1) Reset: rst_n=0 mid-WAIT of STR 0x05<-0xBEEF; release; LDR 0x05 -> rdata!=0xBEEF not required,
//     but no ack during reset and RAM[5] unchanged (preload 0x1111 -> read 0x1111).
//  2) WAIT_STATES=2: STR addr 0x10 wdata 0xA5A5 at edge N -> ack in cycle N+3, busy high N..N+2;
//     then LDR 0x10 -> rdata=0xA5A5 with ack.
//  3) WAIT_STATES=0: LDR back-to-back addrs 0x00,0x01 (preloaded 0x0001,0x0002) -> ack every
//     2nd cycle, rdata 0x0001 then 0x0002.
//  4) rd_mem=wr_mem=1 addr 0x20 -> ack=err=1 one cycle after sample; RAM[0x20] unchanged,
//     rdata holds previous value.
//  5) BOUNDS_CHECK_EN, DEPTH=200: STR addr 0xC8 -> ack+err; LDR 0xC8 -> rdata=0, err=1;
//     macro undefined -> same data, err=0.
//  6) Inputs toggled during WAIT (addr 0x10->0x30): write lands at 0x10 only; ack exactly one cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for LDR/STR strobes; BOUNDS_CHECK_EN flags addr >= DEPTH with err.
// Latency: request sampled at edge N, ack/err pulse in cycle N+WAIT_STATES+1.
// Backpressure: busy held while a request is outstanding; requester holds strobes until ack.
`timescale 1ns/1ps
module data_mem_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 200,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_mem,
   input  logic              wr_mem,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              op_wr, op_wr_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic              err_nxt;

   // Access performed on the edge entering RESP, using either live or latched request fields.
   logic              do_access;
   logic              acc_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              in_range;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_wr_nxt = op_wr;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      err_nxt   = 1'b0;
      do_access = 1'b0;
      acc_wr    = op_wr;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      busy      = 1'b0;
      ack       = 1'b0;
      case (state)
         S_IDLE: begin
            busy      = rd_mem | wr_mem;
            acc_wr    = wr_mem;
            acc_addr  = addr;
            acc_wdata = wdata;
            if (rd_mem & wr_mem) begin
               // Conflicting strobes: no access, complete immediately with err.
               state_nxt = S_RESP;
               err_nxt   = 1'b1;
            end else if (rd_mem | wr_mem) begin
               op_wr_nxt = wr_mem;
               addr_nxt  = addr;
               wdata_nxt = wdata;
               cnt_nxt   = WS;
               if (WS == 4'd0) begin
                  state_nxt = S_RESP;
                  do_access = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            busy    = 1'b1;
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_nxt = S_RESP;
               do_access = 1'b1;
            end
         end
         S_RESP: begin
            ack       = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      in_range = (int'(acc_addr) < DEPTH);
`ifdef BOUNDS_CHECK_EN
      if (do_access && !in_range) err_nxt = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         op_wr   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         op_wr   <= op_wr_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         err     <= err_nxt;
         if (do_access && !acc_wr) begin
            rdata <= in_range ? mem[acc_addr] : '0;
         end
      end
   end

   // RAM is not reset; rst_n gating keeps a held strobe from committing while in reset.
   always_ff @(posedge clk) begin
      if (rst_n && do_access && acc_wr && in_range) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: WAIT_STATES=2 instance with scoreboard, plus a WAIT_STATES=0 instance.
`timescale 1ns/1ps
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rd, wr, ack, busy, err;
   logic [7:0]  addr;
   logic [15:0] wdata, rdata;
   logic        rd0, wr0, ack0, busy0, err0;
   logic [7:0]  addr0;
   logic [15:0] wdata0, rdata0;

   data_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(2)) dut (
      .clk(clk), .rst_n(rst_n), .rd_mem(rd), .wr_mem(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .err(err));

   data_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .rd_mem(rd0), .wr_mem(wr0), .addr(addr0), .wdata(wdata0),
      .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0));

`ifdef BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   typedef struct {
      logic [15:0] rd;
      logic        er;
      int          lat;
   } exp_t;

   int          nvec = 0;
   int          nerr = 0;
   exp_t        sbq[$];
   logic [15:0] model [int];
   logic [15:0] last_rd = 16'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One access on the WAIT_STATES=2 instance; expected result computed from the model and queued.
   task automatic acc(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d,
                      input string tag, input bit toggle = 1'b0);
      exp_t e;
      int   lat;
      bit   inr;
      inr = (a < 8'd200);
      if (r & w) begin
         e.rd = last_rd; e.er = 1'b1; e.lat = 1;
      end else begin
         e.er  = BC && !inr;
         e.lat = 3;
         if (w) begin
            if (inr) model[int'(a)] = d;
            e.rd = last_rd;
         end else begin
            e.rd    = inr ? model[int'(a)] : 16'h0;
            last_rd = e.rd;
         end
      end
      @(negedge clk);
      rd = r; wr = w; addr = a; wdata = d;
      sbq.push_back(e);
      #1 chk({tag, ".busy_req"}, 32'(busy), 32'd1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (toggle && lat == 1) begin
            addr  = 8'h30;
            wdata = 16'hFFFF;
         end
         if (!ack && lat < 20) chk({tag, ".busy_wait"}, 32'(busy), 32'd1);
      end while (!ack && lat < 20);
      e = sbq.pop_front();
      chk({tag, ".lat"}, 32'(lat), 32'(e.lat));
      chk({tag, ".rdata"}, 32'(rdata), 32'(e.rd));
      chk({tag, ".err"}, 32'(err), 32'(e.er));
      chk({tag, ".busy_ack"}, 32'(busy), 32'd0);
      rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      chk({tag, ".ack_pulse"}, 32'(ack), 32'd0);
      chk({tag, ".err_pulse"}, 32'(err), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      rd = 0; wr = 0; addr = 0; wdata = 0;
      rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
      #22;
      chk("rst.rdata", 32'(rdata), 32'd0);
      chk("rst.ack", 32'(ack), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.rdata0", 32'(rdata0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      acc(0, 1, 8'h05, 16'h1111, "pre05");
      acc(0, 1, 8'h20, 16'h2020, "pre20");
      acc(0, 1, 8'h30, 16'h3030, "pre30");

      acc(0, 1, 8'h10, 16'hA5A5, "str10");
      acc(1, 0, 8'h10, 16'h0000, "ldr10");

      // Reset in the middle of the wait of a store; the store must not land.
      @(negedge clk);
      wr = 1'b1; addr = 8'h05; wdata = 16'hBEEF;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.ack", 32'(ack), 32'd0);
      chk("midrst.err", 32'(err), 32'd0);
      chk("midrst.rdata", 32'(rdata), 32'd0);
      wr = 1'b0;
      @(negedge clk);
      chk("midrst.ack2", 32'(ack), 32'd0);
      rst_n = 1'b1;
      last_rd = 16'h0;
      acc(1, 0, 8'h05, 16'h0000, "ldr05");

      acc(1, 1, 8'h20, 16'hDEAD, "dual20");
      acc(1, 0, 8'h20, 16'h0000, "ldr20");

      acc(0, 1, 8'hC8, 16'h7777, "str_oor");
      acc(1, 0, 8'hC8, 16'h0000, "ldr_oor");
      acc(0, 1, 8'hC7, 16'h5A5A, "str_c7");
      acc(1, 0, 8'hC7, 16'h0000, "ldr_c7");

      acc(0, 1, 8'h10, 16'h1234, "str_tog", 1'b1);
      acc(1, 0, 8'h10, 16'h0000, "ldr10_tog");
      acc(1, 0, 8'h30, 16'h0000, "ldr30_tog");

      // Zero-wait instance: held strobe re-issues every second cycle.
      @(negedge clk);
      wr0 = 1'b1; addr0 = 8'h00; wdata0 = 16'h0001;
      #1 chk("z.busy_req", 32'(busy0), 32'd1);
      @(negedge clk);
      chk("z.wack0", 32'(ack0), 32'd1);
      chk("z.wbusy0", 32'(busy0), 32'd0);
      addr0 = 8'h01; wdata0 = 16'h0002;
      @(negedge clk);
      chk("z.wgap", 32'(ack0), 32'd0);
      @(negedge clk);
      chk("z.wack1", 32'(ack0), 32'd1);
      wr0 = 1'b0;
      @(negedge clk);
      chk("z.widle", 32'(ack0), 32'd0);
      rd0 = 1'b1; addr0 = 8'h00;
      @(negedge clk);
      chk("z.rack0", 32'(ack0), 32'd1);
      chk("z.rdata0", 32'(rdata0), 32'h0001);
      chk("z.rerr0", 32'(err0), 32'd0);
      addr0 = 8'h01;
      @(negedge clk);
      chk("z.rgap", 32'(ack0), 32'd0);
      chk("z.rhold", 32'(rdata0), 32'h0001);
      @(negedge clk);
      chk("z.rack1", 32'(ack0), 32'd1);
      chk("z.rdata1", 32'(rdata0), 32'h0002);
      rd0 = 1'b0;
      @(negedge clk);
      chk("z.ridle", 32'(ack0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
